// File: rtl/cpu_bus_debug_master.sv
// cpu_bus_debug_master: framed byte commands to single 32-bit CPU bus transactions; `CPU_BUS_DEBUG_MASTER_AUTOINC_EN adds the 'N' next-word read
module cpu_bus_debug_master #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        bus_request,
  output logic [31:0] bus_address,
  output logic [3:0]  bus_wmask,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);
  localparam logic [2:0] IDLE = 3'd0, ADDR = 3'd1, DATA = 3'd2, BUS = 3'd3, RESP = 3'd4;
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [2:0]  state;
  logic        is_write;
  logic [1:0]  byte_cnt;
  logic [15:0] tmo_cnt;
  logic [31:0] addr;
  logic [31:0] resp_buf;
  logic [2:0]  resp_left;
  logic [31:0] auto_addr;
  logic        rx_fire, tx_fire, bus_done, is_auto;
  assign rx_fire     = rx_valid & rx_ready;
  assign tx_fire     = tx_valid & tx_ready;
  assign bus_done    = bus_ack | (tmo_cnt == TMO_LAST);
  assign bus_address = {addr[31:2], 2'b00};
`ifdef CPU_BUS_DEBUG_MASTER_AUTOINC_EN
  logic [31:0] last_addr;
  assign is_auto   = rx_data == 8'h4E;
  assign auto_addr = last_addr + 32'd4;
  // timed-out transactions still count as "used" for the next 'N'
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) last_addr <= '0;
    else if (state == BUS && bus_done) last_addr <= bus_address;
  end
`else
  assign is_auto   = 1'b0;
  assign auto_addr = '0;
`endif
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      rx_ready    <= 1'b0;
      tx_valid    <= 1'b0;
      tx_data     <= '0;
      bus_request <= 1'b0;
      bus_wmask   <= '0;
      bus_wdata   <= '0;
      addr        <= '0;
      is_write    <= 1'b0;
      byte_cnt    <= '0;
      tmo_cnt     <= '0;
      resp_buf    <= '0;
      resp_left   <= '0;
    end else begin
      tmo_cnt <= (state == BUS) ? tmo_cnt + 16'd1 : '0;
      case (state)
        IDLE: begin
          rx_ready <= 1'b1;
          byte_cnt <= '0;
          if (rx_fire) begin
            is_write <= rx_data == 8'h57;
            if (rx_data == 8'h52 || rx_data == 8'h57) begin
              state <= ADDR;
            end else if (is_auto) begin
              addr        <= auto_addr;
              state       <= BUS;
              rx_ready    <= 1'b0;
              bus_request <= 1'b1;
            end else begin
              state     <= RESP;
              rx_ready  <= 1'b0;
              tx_valid  <= 1'b1;
              tx_data   <= 8'h3F;
              resp_left <= 3'd1;
            end
          end
        end
        ADDR: if (rx_fire) begin
          addr     <= {addr[23:0], rx_data};
          byte_cnt <= byte_cnt + 2'd1;
          if (byte_cnt == 2'd3) begin
            state       <= is_write ? DATA : BUS;
            rx_ready    <= is_write;
            bus_request <= !is_write;
          end
        end
        DATA: if (rx_fire) begin
          bus_wdata <= {bus_wdata[23:0], rx_data};
          byte_cnt  <= byte_cnt + 2'd1;
          if (byte_cnt == 2'd3) begin
            state       <= BUS;
            rx_ready    <= 1'b0;
            bus_request <= 1'b1;
            bus_wmask   <= 4'hF;
          end
        end
        BUS: if (bus_done) begin
          state       <= RESP;
          bus_request <= 1'b0;
          bus_wmask   <= '0;
          tx_valid    <= 1'b1;
          tx_data     <= !bus_ack ? 8'h54 : is_write ? 8'h77 : 8'h72;
          resp_left   <= (bus_ack && !is_write) ? 3'd5 : 3'd1;
          resp_buf    <= bus_rdata;
        end
        RESP: if (tx_fire) begin
          if (resp_left == 3'd1) begin
            state    <= IDLE;
            tx_valid <= 1'b0;
            rx_ready <= 1'b1;
          end
          tx_data   <= resp_buf[31:24];
          resp_buf  <= resp_buf << 8;
          resp_left <= resp_left - 3'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cpu_bus_debug_master.sv
// tb_cpu_bus_debug_master: random framed commands against a queue-based reference model and scoreboard
module tb_cpu_bus_debug_master;
  localparam int TMO = 16;
  logic        clk = 1'b0, reset_n = 1'b0;
  logic        rx_valid = 1'b0, rx_ready, tx_valid, tx_ready = 1'b0;
  logic [7:0]  rx_data = '0, tx_data;
  logic        bus_request, bus_ack = 1'b0;
  logic [31:0] bus_address, bus_wdata, bus_rdata = '0;
  logic [3:0]  bus_wmask;
  typedef struct {
    logic [31:0] addr;
    logic [3:0]  wmask;
    logic [31:0] wdata;
    bit          ack;
    int          d;
    logic [31:0] rdata;
  } txn_t;
  txn_t        plan_q[$];
  logic [7:0]  exp_q[$];
  int          n_chk = 0, n_fail = 0;
  bit          hold_tx = 1'b0;
  logic [31:0] model_last = '0;
  always #5 clk = ~clk;
  cpu_bus_debug_master #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset_n(reset_n),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .bus_request(bus_request), .bus_address(bus_address), .bus_wmask(bus_wmask),
    .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic check_reset_outputs();
    chk("rst_rx_ready", rx_ready, 0);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_bus_request", bus_request, 0);
    chk("rst_bus_address", bus_address, 0);
    chk("rst_bus_wmask", bus_wmask, 0);
    chk("rst_bus_wdata", bus_wdata, 0);
  endtask
  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    @(posedge clk);
    #1 rx_valid = 1'b1;
    rx_data = b;
    do begin
      @(negedge clk);
      t++;
    end while (!rx_ready && t < 300);
    if (!rx_ready) begin
      n_chk++;
      n_fail++;
      $display("FAIL rx_accept: byte %h waited, rx_ready=0 required 1", b);
    end
    @(posedge clk);
    #1 rx_valid = 1'b0;
  endtask
  // reference model: expected bus transaction and response bytes from the command rules
  task automatic do_frame(input logic [7:0] cmd, input logic [31:0] a, input logic [31:0] w,
                          input bit ack, input int d, input logic [31:0] rd);
    txn_t p;
    bit known = 1'b1;
    p.ack = ack; p.d = d; p.rdata = rd; p.wdata = w;
    if (cmd == 8'h52 || cmd == 8'h57) p.addr = a & ~32'd3;
`ifdef CPU_BUS_DEBUG_MASTER_AUTOINC_EN
    else if (cmd == 8'h4E) p.addr = model_last + 32'd4;
`endif
    else known = 1'b0;
    if (known) begin
      p.wmask = (cmd == 8'h57) ? 4'hF : 4'h0;
      model_last = p.addr;
      plan_q.push_back(p);
      if (!ack) exp_q.push_back(8'h54);
      else if (cmd == 8'h57) exp_q.push_back(8'h77);
      else begin
        exp_q.push_back(8'h72);
        for (int i = 3; i >= 0; i--) exp_q.push_back(rd[8*i +: 8]);
      end
    end else exp_q.push_back(8'h3F);
    send_byte(cmd);
    if (cmd == 8'h52 || cmd == 8'h57) for (int i = 3; i >= 0; i--) send_byte(a[8*i +: 8]);
    if (cmd == 8'h57) for (int i = 3; i >= 0; i--) send_byte(w[8*i +: 8]);
    repeat ($urandom_range(0, 2)) @(posedge clk);
  endtask
  task automatic drain();
    int t = 0;
    while ((exp_q.size() != 0 || plan_q.size() != 0 || tx_valid || bus_request) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    chk("drain_outstanding", exp_q.size() + plan_q.size(), 0);
  endtask
  initial forever begin
    @(posedge clk);
    #1 tx_ready = !hold_tx && ($urandom_range(0, 3) != 0);
  end
  // tx monitor: pops expected bytes and checks hold-under-backpressure
  initial begin
    logic [7:0] last_d;
    bit stall;
    last_d = '0;
    stall = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        stall = 1'b0;
        continue;
      end
      if (stall) begin
        chk("tx_hold_valid", tx_valid, 1);
        chk("tx_hold_data", tx_data, last_d);
      end
      if (tx_valid && tx_ready) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL tx_extra_byte: got %h expected none", tx_data);
        end else chk("tx_byte", tx_data, exp_q.pop_front());
      end
      stall = tx_valid && !tx_ready;
      last_d = tx_data;
    end
  end
  // bus responder and checker
  initial begin
    txn_t p;
    bit active;
    int cyc;
    active = 1'b0;
    cyc = 0;
    forever begin
      @(negedge clk);
      bus_ack = 1'b0;
      if (!reset_n) begin
        active = 1'b0;
        continue;
      end
      if (active && !bus_request) begin
        chk("req_cycles", cyc, p.ack ? p.d + 1 : TMO);
        chk("resp_latency", tx_valid, 1);
        active = 1'b0;
      end else if (bus_request) begin
        if (!active) begin
          active = 1'b1;
          cyc = 0;
          if (plan_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL bus_unexpected: request at %h expected none", bus_address);
            p = '{addr: bus_address, wmask: bus_wmask, wdata: bus_wdata, ack: 1'b1, d: 0, rdata: '0};
          end else p = plan_q.pop_front();
        end
        chk("bus_address", bus_address, p.addr);
        chk("bus_wmask", bus_wmask, p.wmask);
        if (p.wmask == 4'hF) chk("bus_wdata", bus_wdata, p.wdata);
        cyc++;
        if (p.ack && cyc == p.d + 1) begin
          bus_ack = 1'b1;
          bus_rdata = p.rdata;
        end
      end else if ($urandom_range(0, 7) == 0) begin
        bus_ack = 1'b1;
        bus_rdata = $urandom;
      end
    end
  end
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    int t;
    logic [7:0] b;
    logic [31:0] a, w, rd;
    int r;
    repeat (2) @(negedge clk);
    check_reset_outputs();
    @(posedge clk);
    #1 reset_n = 1'b1;
    do_frame(8'h57, 32'h0000_0100, 32'hDEAD_BEEF, 1'b1, 2, 32'h0);
    do_frame(8'h52, 32'h0000_0104, 32'h0, 1'b1, 0, 32'h1234_5678);
    do_frame(8'h52, 32'h0000_0108, 32'h0, 1'b0, 0, 32'h0);
    do_frame(8'h52, 32'h0000_010C, 32'h0, 1'b1, TMO - 1, 32'hCAFE_F00D);
    do_frame(8'h52, 32'h0000_0200, 32'h0, 1'b1, 3, 32'hA5B6_C7D8);
    t = 0;
    while (!tx_valid && t < 200) begin
      @(negedge clk);
      t++;
    end
    @(posedge clk);
    #1 hold_tx = 1'b1;
    repeat (10) @(posedge clk);
    #1 hold_tx = 1'b0;
    do_frame(8'h41, 32'h0, 32'h0, 1'b1, 0, 32'h0);
    do_frame(8'h52, 32'hFFFF_FFFE, 32'h0, 1'b1, 1, 32'h0BAD_CAFE);
    do_frame(8'h4E, 32'h0, 32'h0, 1'b1, 0, 32'h1111_2222);
    drain();
    send_byte(8'h52);
    for (int i = 0; i < 3; i++) send_byte(8'h33);
    @(posedge clk);
    #1 reset_n = 1'b0;
    #1 check_reset_outputs();
    model_last = '0;
    @(posedge clk);
    #1 reset_n = 1'b1;
    do_frame(8'h52, 32'h0000_0400, 32'h0, 1'b1, 1, 32'h8765_4321);
    for (int n = 0; n < 40; n++) begin
      r = $urandom_range(0, 9);
      a = $urandom;
      w = $urandom;
      rd = $urandom;
      if (r < 4) b = 8'h52;
      else if (r < 7) b = 8'h57;
      else if (r == 7) b = 8'h4E;
      else begin
        do b = 8'($urandom); while (b == 8'h52 || b == 8'h57);
      end
      do_frame(b, a, w, $urandom_range(0, 5) != 0, $urandom_range(0, TMO - 1), rd);
    end
    drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/cpu_bus_debug_master.md
Name: cpu_bus_debug_master

Overview:
- Byte-stream-to-CPU-bus initiator, the opposite end of the CPU bus from the peripheral responders.
- Accepts framed commands over a byte stream (valid/ready), typically fed by the UART RX path.
- Issues single 32-bit read or write transactions on a CPU bus initiator port and streams framed responses back out.
- Used for host-side debug access to CPU RAM, registers and SDRAM without firmware involvement.

Parameters:
- TIMEOUT_CYCLES, 1024: clock cycles to wait for bus_ack before aborting a transaction; legal range 1..65535.

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- rx_valid  input  1  inbound byte valid
- rx_data  input  8  inbound byte
- rx_ready  output  1  inbound byte accepted when rx_valid & rx_ready
- tx_valid  output  1  outbound byte valid
- tx_data  output  8  outbound byte
- tx_ready  input  1  outbound byte consumed when tx_valid & tx_ready
- bus_request  output  1  transaction request, held until ack or timeout
- bus_address  output  32  byte address, word aligned (bits [1:0] forced 0)
- bus_wmask  output  4  byte write enables; 4'b0000 = read, 4'b1111 = write
- bus_wdata  output  32  write data
- bus_ack  input  1  responder completion, single-cycle pulse
- bus_rdata  input  32  read data, valid in the bus_ack cycle

Behaviour:
- Reset (async assert, sync deassert inside clk domain) values:
  - rx_ready=0, tx_valid=0, tx_data=0, bus_request=0, bus_address=0, bus_wmask=0, bus_wdata=0.
  - FSM=IDLE, all counters 0.
- Frame format, all multi-byte fields MSB first:
  - Read: 0x52 'R' + 4 address bytes.
  - Write: 0x57 'W' + 4 address bytes + 4 data bytes.
- FSM states: IDLE, ADDR, DATA, BUS, RESP.
- IDLE:
  - rx_ready=1.
  - On accepting 'R' or 'W': latch op, go to ADDR, byte counter=0.
  - Any other byte: queue response 0x3F '?', go to RESP.
- ADDR:
  - rx_ready=1; shift each accepted byte into address.
  - After the 4th byte: read goes to BUS; write goes to DATA.
- DATA:
  - rx_ready=1; shift 4 bytes into wdata, then go to BUS.
- BUS:
  - rx_ready=0; bus_request=1 from the first BUS cycle.
  - bus_address, bus_wmask and bus_wdata are stable while bus_request=1.
  - Timeout counter increments every cycle.
  - bus_ack: bus_request drops the next cycle; capture bus_rdata on reads; go to RESP.
    - Read response: 0x72 'r' + 4 rdata bytes.
    - Write response: 0x77 'w'.
  - Counter reaches TIMEOUT_CYCLES without ack: drop request, respond 0x54 'T'.
  - bus_ack arriving in the same cycle as expiry: ack wins.
  - bus_ack while bus_request=0: ignored.
- RESP:
  - tx_valid=1 with the current byte; advance only on tx_ready.
  - tx_data must not change while tx_valid=1 and tx_ready=0.
  - After the last byte: tx_valid=0 next cycle, go to IDLE.
  - rx_ready=0 throughout.
- No inter-byte timeout; a partial frame waits indefinitely.
- reset_n asserted mid-transaction:
  - All outputs return to reset values immediately.
  - The partial frame is discarded; no response is sent.
- Latency: bus_request rises 1 cycle after the last frame byte is accepted. The first response byte is valid 1 cycle after bus_ack.

Optional Feature:
- Macro: CPU_BUS_DEBUG_MASTER_AUTOINC_EN.
- Defined:
  - Command 0x4E 'N' reads from the last used address + 4 (32-bit wrap, 0xFFFFFFFC -> 0x00000000).
  - 'N' skips ADDR and goes directly to BUS; the response is identical to 'R'.
  - The last-address register resets to 0 and updates on every R, W or N transaction, including timed-out ones.
- Undefined: 'N' is treated as an unknown command and answered with '?'.

Test Plan:
- Write: bytes 57 00 00 01 00 DE AD BE EF, ack after 3 cycles -> bus_address=0x00000100, wmask=F, wdata=0xDEADBEEF, request held exactly until ack; tx emits 77.
- Read: bytes 52 00 00 01 04, ack with rdata=0x12345678 -> wmask=0; tx emits 72 12 34 56 78 in order.
- Timeout: TIMEOUT_CYCLES=16, read with no ack -> request high for 16 cycles then low; tx emits 54. Ack on cycle 16 -> 72 + data instead.
- Backpressure and unknown command: tx_ready=0 for 10 cycles during a read response -> tx_data stable, no byte lost. Byte 0x41 -> tx emits 3F; the FSM then accepts a new frame.
- Reset mid-frame: assert reset_n after 3 address bytes -> outputs return to reset values; a following full read frame executes correctly.
- AUTOINC (macro defined): R at 0xFFFFFFFC then N -> second bus_address=0x00000000. Macro undefined: N -> 3F.
